// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding for the ALU.
// Optional load-use bubble insertion is enabled by defining LOADUSE_STALL_EN.
module ex_operand_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_signimm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [2:0]    id_alucont,
  input  logic          id_alusrc,
  input  logic          id_regdst,
  input  logic          id_regwrite,
  input  logic          id_memtoreg,
  input  logic          id_memwrite,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_writereg,
  input  logic [DW-1:0] mem_aluout,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_writereg,
  input  logic [DW-1:0] wb_result,
  output logic          ex_valid,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_cont,
  output logic [DW-1:0] ex_writedata,
  output logic [RW-1:0] ex_writereg,
  output logic          ex_regwrite,
  output logic          ex_memtoreg,
  output logic          ex_memwrite,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          load_use_stall
);

  localparam logic [1:0] FwdReg = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  logic          valid_q,    valid_d;
  logic [DW-1:0] rd1_q,      rd1_d;
  logic [DW-1:0] rd2_q,      rd2_d;
  logic [DW-1:0] signimm_q,  signimm_d;
  logic [RW-1:0] rs_q,       rs_d;
  logic [RW-1:0] rt_q,       rt_d;
  logic [RW-1:0] rd_q,       rd_d;
  logic [2:0]    alucont_q,  alucont_d;
  logic          alusrc_q,   alusrc_d;
  logic          regdst_q,   regdst_d;
  logic          regwrite_q, regwrite_d;
  logic          memtoreg_q, memtoreg_d;
  logic          memwrite_q, memwrite_d;
  logic          bubble;

`ifdef LOADUSE_STALL_EN
  // Loaded value is not available until MEM/WB, so a dependent instruction must wait a cycle.
  assign load_use_stall = valid_q && memtoreg_q && id_valid && (ex_writereg != '0) &&
                          ((ex_writereg == id_rs) || (ex_writereg == id_rt));
  assign bubble = flush | load_use_stall;
`else
  assign load_use_stall = 1'b0;
  assign bubble = flush;
`endif

  always_comb begin
    valid_d    = valid_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    signimm_d  = signimm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    alucont_d  = alucont_q;
    alusrc_d   = alusrc_q;
    regdst_d   = regdst_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memwrite_d = memwrite_q;
    if (bubble) begin
      valid_d    = 1'b0;
      rd1_d      = '0;
      rd2_d      = '0;
      signimm_d  = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      alucont_d  = '0;
      alusrc_d   = 1'b0;
      regdst_d   = 1'b0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      memwrite_d = 1'b0;
    end else if (!stall) begin
      valid_d    = id_valid;
      rd1_d      = id_rd1;
      rd2_d      = id_rd2;
      signimm_d  = id_signimm;
      rs_d       = id_rs;
      rt_d       = id_rt;
      rd_d       = id_rd;
      alucont_d  = id_alucont;
      alusrc_d   = id_alusrc;
      regdst_d   = id_regdst;
      regwrite_d = id_regwrite;
      memtoreg_d = id_memtoreg;
      memwrite_d = id_memwrite;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      signimm_q  <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      alucont_q  <= '0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      signimm_q  <= signimm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      alucont_q  <= alucont_d;
      alusrc_q   <= alusrc_d;
      regdst_q   <= regdst_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memwrite_q <= memwrite_d;
    end
  end

  // MEM is checked first: it holds the younger producer when both stages match.
  always_comb begin
    fwd_a = FwdReg;
    if (valid_q && mem_regwrite && (mem_writereg != '0) && (mem_writereg == rs_q)) begin
      fwd_a = FwdMem;
    end else if (valid_q && wb_regwrite && (wb_writereg != '0) && (wb_writereg == rs_q)) begin
      fwd_a = FwdWb;
    end
    fwd_b = FwdReg;
    if (valid_q && mem_regwrite && (mem_writereg != '0) && (mem_writereg == rt_q)) begin
      fwd_b = FwdMem;
    end else if (valid_q && wb_regwrite && (wb_writereg != '0) && (wb_writereg == rt_q)) begin
      fwd_b = FwdWb;
    end
  end

  always_comb begin
    unique case (fwd_a)
      FwdMem:  alu_a = mem_aluout;
      FwdWb:   alu_a = wb_result;
      default: alu_a = rd1_q;
    endcase
    unique case (fwd_b)
      FwdMem:  ex_writedata = mem_aluout;
      FwdWb:   ex_writedata = wb_result;
      default: ex_writedata = rd2_q;
    endcase
  end

  assign alu_b       = alusrc_q ? signimm_q : ex_writedata;
  assign ex_writereg = regdst_q ? rd_q : rt_q;
  assign ex_valid    = valid_q;
  assign alu_cont    = alucont_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memtoreg = memtoreg_q;
  assign ex_memwrite = memwrite_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed vector bench for ex_operand_stage: forwarding table plus reset, stall/flush
// and load-use sequences.
module tb_ex_operand_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  alucont;
    logic        alusrc, regdst, regwrite, memtoreg, memwrite;
    logic        mrw;
    logic [4:0]  mwr;
    logic [31:0] malu;
    logic        wrw;
    logic [4:0]  wwr;
    logic [31:0] wres;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] a, b;
    logic [2:0]  cont;
    logic [31:0] wd;
    logic [4:0]  wreg;
    logic        rw, mtr, mw;
    logic [1:0]  fa, fb;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n, stall, flush, id_valid;
  logic [31:0] id_rd1, id_rd2, id_signimm, mem_aluout, wb_result;
  logic [4:0]  id_rs, id_rt, id_rd, mem_writereg, wb_writereg;
  logic [2:0]  id_alucont;
  logic id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite, mem_regwrite, wb_regwrite;
  logic ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, load_use_stall;
  logic [31:0] alu_a, alu_b, ex_writedata;
  logic [2:0]  alu_cont;
  logic [4:0]  ex_writereg;
  logic [1:0]  fwd_a, fwd_b;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[7];
  out_t zero_out;

  always #5 clk = ~clk;

  ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_signimm(id_signimm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_alucont(id_alucont), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
    .mem_regwrite(mem_regwrite), .mem_writereg(mem_writereg), .mem_aluout(mem_aluout),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_result(wb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont),
    .ex_writedata(ex_writedata), .ex_writereg(ex_writereg), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .load_use_stall(load_use_stall)
  );

  function automatic in_t mk_in(logic v, logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                                logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [2:0] alucont, logic [4:0] ctl, logic mrw, logic [4:0] mwr,
                                logic [31:0] malu, logic wrw, logic [4:0] wwr,
                                logic [31:0] wres);
    in_t r;
    r.v = v; r.rd1 = rd1; r.rd2 = rd2; r.imm = imm; r.rs = rs; r.rt = rt; r.rd = rd;
    r.alucont = alucont;
    // ctl = {alusrc, regdst, regwrite, memtoreg, memwrite}
    {r.alusrc, r.regdst, r.regwrite, r.memtoreg, r.memwrite} = ctl;
    r.mrw = mrw; r.mwr = mwr; r.malu = malu; r.wrw = wrw; r.wwr = wwr; r.wres = wres;
    return r;
  endfunction

  function automatic out_t mk_out(logic valid, logic [31:0] a, logic [31:0] b, logic [2:0] cont,
                                  logic [31:0] wd, logic [4:0] wreg, logic [2:0] ctl,
                                  logic [1:0] fa, logic [1:0] fb);
    out_t r;
    r.valid = valid; r.a = a; r.b = b; r.cont = cont; r.wd = wd; r.wreg = wreg;
    {r.rw, r.mtr, r.mw} = ctl;
    r.fa = fa; r.fb = fb;
    return r;
  endfunction

  task automatic drive(input in_t i);
    id_valid = i.v; id_rd1 = i.rd1; id_rd2 = i.rd2; id_signimm = i.imm;
    id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; id_alucont = i.alucont;
    id_alusrc = i.alusrc; id_regdst = i.regdst; id_regwrite = i.regwrite;
    id_memtoreg = i.memtoreg; id_memwrite = i.memwrite;
    mem_regwrite = i.mrw; mem_writereg = i.mwr; mem_aluout = i.malu;
    wb_regwrite = i.wrw; wb_writereg = i.wwr; wb_result = i.wres;
  endtask

  task automatic check_out(input string name, input out_t e);
    out_t act;
    act.valid = ex_valid; act.a = alu_a; act.b = alu_b; act.cont = alu_cont;
    act.wd = ex_writedata; act.wreg = ex_writereg; act.rw = ex_regwrite;
    act.mtr = ex_memtoreg; act.mw = ex_memwrite; act.fa = fwd_a; act.fb = fwd_b;
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got v=%b a=%h b=%h cont=%b wd=%h wreg=%0d ctl=%b%b%b fa=%b fb=%b, want v=%b a=%h b=%h cont=%b wd=%h wreg=%0d ctl=%b%b%b fa=%b fb=%b",
               name, act.valid, act.a, act.b, act.cont, act.wd, act.wreg, act.rw, act.mtr,
               act.mw, act.fa, act.fb, e.valid, e.a, e.b, e.cont, e.wd, e.wreg, e.rw, e.mtr,
               e.mw, e.fa, e.fb);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  initial begin
    in_t lw, use9;
    zero_out = '0;
    //                  v  rd1          rd2          imm           rs rt rd  op     ctl
    vecs[0].in  = mk_in(1, 32'h5,       32'h7,       32'h10,       1, 2, 3, 3'b010, 5'b01100,
                        0, 0, 32'h0,  0, 0, 32'h0);
    vecs[0].exp = mk_out(1, 32'h5, 32'h7, 3'b010, 32'h7, 3, 3'b100, 2'b00, 2'b00);
    vecs[1].in  = mk_in(1, 32'hA,       32'hB,       32'h0,        8, 8, 4, 3'b010, 5'b00100,
                        1, 8, 32'h11, 1, 8, 32'h22);
    vecs[1].exp = mk_out(1, 32'h11, 32'h11, 3'b010, 32'h11, 8, 3'b100, 2'b10, 2'b10);
    vecs[2].in  = mk_in(1, 32'h1,       32'h2,       32'h0,        9, 10, 11, 3'b110, 5'b01100,
                        1, 10, 32'h33, 1, 9, 32'h44);
    vecs[2].exp = mk_out(1, 32'h44, 32'h33, 3'b110, 32'h33, 11, 3'b100, 2'b01, 2'b10);
    vecs[3].in  = mk_in(1, 32'h55,      32'h66,      32'hFFFFFFFC, 0, 6, 7, 3'b010, 5'b10100,
                        1, 0, 32'h77, 1, 6, 32'h88);
    vecs[3].exp = mk_out(1, 32'h55, 32'hFFFFFFFC, 3'b010, 32'h88, 6, 3'b100, 2'b00, 2'b01);
    vecs[4].in  = mk_in(1, 32'h12,      32'h34,      32'h0,        3, 3, 5, 3'b000, 5'b00001,
                        0, 3, 32'hAA, 0, 3, 32'hBB);
    vecs[4].exp = mk_out(1, 32'h12, 32'h34, 3'b000, 32'h34, 3, 3'b001, 2'b00, 2'b00);
    vecs[5].in  = mk_in(0, 32'hDEAD,    32'hBEEF,    32'h0,        5, 5, 1, 3'b001, 5'b00000,
                        1, 5, 32'hCC, 1, 5, 32'hDD);
    vecs[5].exp = mk_out(0, 32'hDEAD, 32'hBEEF, 3'b001, 32'hBEEF, 5, 3'b000, 2'b00, 2'b00);
    vecs[6].in  = mk_in(1, 32'h100,     32'h200,     32'h4,        1, 12, 2, 3'b010, 5'b10110,
                        0, 0, 32'h0,  0, 0, 32'h0);
    vecs[6].exp = mk_out(1, 32'h100, 32'h4, 3'b010, 32'h200, 12, 3'b110, 2'b00, 2'b00);

    reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(vecs[0].in);
    repeat (2) @(posedge clk);
    #1 check_out("reset_idle", zero_out);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk) drive(vecs[i].in);
      @(posedge clk);
      #1 check_out($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset mid-cycle with valid contents.
    @(negedge clk) drive(vecs[0].in);
    @(posedge clk);
    #1 check_out("pre_reset", vecs[0].exp);
    #2 reset_n = 1'b0;
    #1 check_out("async_reset", zero_out);
    @(negedge clk) reset_n = 1'b1;

    // Stall holds for two cycles, then flush wins over stall.
    @(negedge clk) drive(vecs[0].in);
    @(posedge clk);
    #1 check_out("stall_load", vecs[0].exp);
    @(negedge clk) begin
      drive(vecs[2].in);
      mem_regwrite = 1'b0; wb_regwrite = 1'b0;
      stall = 1'b1;
    end
    @(posedge clk);
    #1 check_out("stall_1", vecs[0].exp);
    @(posedge clk);
    #1 check_out("stall_2", vecs[0].exp);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 check_out("flush_over_stall", zero_out);
    @(negedge clk) begin stall = 1'b0; flush = 1'b0; end

    // Load into $9 followed by a dependent instruction.
    lw   = mk_in(1, 32'h0, 32'h0, 32'h8, 2, 9, 0, 3'b010, 5'b10110, 0, 0, 32'h0, 0, 0, 32'h0);
    use9 = mk_in(1, 32'h3, 32'h4, 32'h0, 9, 4, 6, 3'b010, 5'b01100, 0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk) drive(lw);
    @(posedge clk);
    #1 check_out("lw_in_ex", mk_out(1, 32'h0, 32'h8, 3'b010, 32'h0, 9, 3'b110, 2'b00, 2'b00));
    @(negedge clk) drive(use9);
    #1;
`ifdef LOADUSE_STALL_EN
    check_bit("load_use_on", load_use_stall, 1'b1);
    @(posedge clk);
    #1 check_out("load_use_bubble", zero_out);
    check_bit("load_use_clear", load_use_stall, 1'b0);
    @(negedge clk) begin wb_regwrite = 1'b1; wb_writereg = 5'd9; wb_result = 32'h99; end
    @(posedge clk);
    #1 check_out("wb_fwd_after_load",
                 mk_out(1, 32'h99, 32'h4, 3'b010, 32'h4, 6, 3'b100, 2'b01, 2'b00));
`else
    check_bit("load_use_off", load_use_stall, 1'b0);
    @(posedge clk);
    #1 check_out("no_bubble", mk_out(1, 32'h3, 32'h4, 3'b010, 32'h4, 6, 3'b100, 2'b00, 2'b00));
    wb_regwrite = 1'b1; wb_writereg = 5'd9; wb_result = 32'h99;
    #1 check_out("wb_fwd_after_load",
                 mk_out(1, 32'h99, 32'h4, 3'b010, 32'h4, 6, 3'b100, 2'b01, 2'b00));
    check_bit("load_use_still_off", load_use_stall, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
